// File: rtl/cmd_dispatcher.sv
// Command framer: buffers {length, mask, payload...} frames in a FWFT FIFO and
// broadcasts each payload word to the selected targets, collecting acknowledges.
module cmd_dispatcher #(
  parameter int DATA_W    = 8,
  parameter int N_TARGETS = 8,
  parameter int DEPTH     = 256,
  parameter int ACK_ALL   = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_W-1:0]    cmd_in,
  input  logic                 cmd_wr,
  output logic                 cmd_full,
  output logic [N_TARGETS-1:0] cmd_mask,
  output logic [DATA_W-1:0]    data,
  input  logic [N_TARGETS-1:0] data_ack,
  output logic                 cmd_done,
  output logic                 busy,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic                 overflow,
  input  logic                 clr_err
);

  localparam int DEPTH_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_WAIT, S_SEND, S_DISCARD, S_FLUSH, S_DONE
  } state_t;

  state_t                 state;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DEPTH_W-1:0]     wr_ptr, rd_ptr;
  logic [DEPTH_W:0]       count;
  logic [DATA_W-1:0]      head;
  logic [DATA_W-1:0]      len_r;
  logic [N_TARGETS-1:0]   mask_r;
  logic [N_TARGETS-1:0]   pending;
  logic [DATA_W-1:0]      sent;
  logic [31:0]            wait_cnt;
  logic                   empty, wr_acc, pop, fifo_pop, adv, frame_rdy, oversize;

  // Full is judged on the registered count, so a same-cycle pop cannot make room.
  assign head      = mem[rd_ptr];
  assign empty     = (count == '0);
  assign cmd_full  = (count == (DEPTH_W+1)'(DEPTH));
  assign wr_acc    = cmd_wr && !cmd_full;
  assign frame_rdy = int'(count) >= int'(len_r) + 1;
  assign oversize  = int'(head) + 1 > DEPTH - 1;

  assign busy     = (state != S_IDLE);
  assign cmd_mask = (state == S_SEND) ? mask_r : '0;
  assign data     = (state == S_SEND) ? head : '0;

  always_comb begin
    pop = 1'b0;
    if (ACK_ALL != 0) adv = ((pending & ~data_ack) == '0);
    else              adv = ((data_ack & mask_r) != '0);
    case (state)
      S_LEN:     pop = 1'b1;
      S_WAIT:    pop = frame_rdy;
      S_SEND:    pop = adv;
      S_DISCARD: pop = (len_r != '0);
      S_FLUSH:   pop = !empty;
      default:   pop = 1'b0;
    endcase
  end

  assign fifo_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (state == S_LEN) len_r <= head;
    if (state == S_WAIT && frame_rdy) mask_r <= head[N_TARGETS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pending   <= '0;
      sent      <= '0;
      wait_cnt  <= '0;
      cmd_done  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
      overflow  <= 1'b0;
    end else begin
      cmd_done  <= 1'b0;
      err_valid <= 1'b0;
      // Clear first so an overflow or error in the same cycle survives.
      if (clr_err) begin
        overflow <= 1'b0;
        err_code <= 2'd0;
      end
      if (cmd_wr && cmd_full) overflow <= 1'b1;

      if (wr_acc)   wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        S_IDLE: if (!empty) state <= S_LEN;
        S_LEN: begin
          if (oversize) begin
            state     <= S_FLUSH;
            err_valid <= 1'b1;
            err_code  <= 2'd2;
          end else begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (frame_rdy) begin
            sent <= '0;
            if (head[N_TARGETS-1:0] == '0) begin
              state     <= S_DISCARD;
              err_valid <= 1'b1;
              err_code  <= 2'd3;
            end else if (len_r == '0) begin
              state    <= S_DONE;
              cmd_done <= 1'b1;
            end else begin
              pending <= head[N_TARGETS-1:0];
              state   <= S_SEND;
            end
          end else if (TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT - 1)) begin
            state     <= S_FLUSH;
            err_valid <= 1'b1;
            err_code  <= 2'd1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_SEND: begin
          if (adv) begin
            if (sent + 1'b1 == len_r) begin
              state    <= S_DONE;
              cmd_done <= 1'b1;
            end else begin
              sent    <= sent + 1'b1;
              pending <= mask_r;
            end
          end else begin
            pending <= pending & ~data_ack;
          end
        end
        S_DISCARD: begin
          if (len_r == '0 || sent + 1'b1 == len_r) state <= S_IDLE;
          else                                     sent  <= sent + 1'b1;
        end
        // Keep draining while words keep arriving; leave only on a quiet, empty cycle.
        S_FLUSH: if (empty && !wr_acc) state <= S_IDLE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
